msk_rnd_gen: RTL

MSK_RND_GEN -- requirements
Module: msk_rnd_gen

---
 rtl/msk_pkg.sv | 14 +
 rtl/msk_lfsr_step.sv | 17 +
 rtl/msk_rnd_gen.sv | 90 +++++++++
 3 files changed

// File: rtl/msk_pkg.sv
// Shared constants and state encoding for the masking randomness source.
package msk_pkg;

    // Fibonacci taps for x^64+x^63+x^61+x^60+1: bits 63, 62, 60, 59
    localparam logic [63:0] LFSR_TAPS     = 64'hD800_0000_0000_0000;
    localparam logic [63:0] ZERO_SEED_SUB = 64'h0000_0000_0000_0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/msk_lfsr_step.sv
// Unrolled N-step advance of the 64-bit Fibonacci LFSR (combinational).
module msk_lfsr_step #(
    parameter int N = 1
) (
    input  logic [63:0] s,
    output logic [63:0] s_next
);
    import msk_pkg::*;

    always_comb begin
        s_next = s;
        for (int i = 0; i < N; i++) begin
            s_next = {s_next[62:0], ^(s_next & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/msk_rnd_gen.sv
// LFSR-based fresh-randomness source for masked gadgets, with seeding,
// warm-up and a transfer budget that requests a reseed when spent.
module msk_rnd_gen #(
    parameter int d            = 2,
    parameter int WARMUP       = 8,
    parameter int RESEED_LIMIT = 65535,
    localparam int n_rnd       = d * (d - 1) / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      seed_in,
    input  logic             seed_valid,
    output logic             seed_ready,
    output logic [n_rnd-1:0] rnd_out,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             reseed_req
);
    import msk_pkg::*;

    localparam logic [7:0]  WU  = 8'(WARMUP);
    localparam logic [15:0] LIM = 16'(RESEED_LIMIT);

    state_t      state;
    state_t      state_n;
    logic [63:0] s;
    logic [63:0] s_adv;
    logic [7:0]  wcnt;
    logic [15:0] tcnt;
    logic        rdy;
    logic        req;
    logic        seed_fire;
    logic        rnd_fire;

    msk_lfsr_step #(.N(n_rnd)) u_step (
        .s      (s),
        .s_next (s_adv)
    );

    assign seed_ready = rdy;
    assign rnd_valid  = (state == RUN);
    // Gated so nothing leaks out of the LFSR outside RUN
    assign rnd_out    = rnd_valid ? s[n_rnd-1:0] : '0;
    assign reseed_req = req;
    assign seed_fire  = seed_valid & rdy;
    assign rnd_fire   = rnd_valid & rnd_ready;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = IDLE;
            WARM:    if (wcnt == WU) state_n = RUN;
            RUN:     state_n = RUN;
            default: state_n = IDLE;
        endcase
        if (seed_fire) state_n = WARM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // WARM spends one extra cycle at wcnt==WU without advancing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s    <= ZERO_SEED_SUB;
            wcnt <= '0;
            tcnt <= '0;
            req  <= 1'b0;
            rdy  <= 1'b0;
        end else begin
            rdy <= 1'b1;
            if (seed_fire) begin
                s    <= (seed_in == '0) ? ZERO_SEED_SUB : seed_in;
                wcnt <= '0;
                tcnt <= '0;
                req  <= 1'b0;
            end else if (state == WARM && wcnt != WU) begin
                s    <= s_adv;
                wcnt <= wcnt + 8'd1;
            end else if (rnd_fire) begin
                s <= s_adv;
                if (tcnt != LIM) tcnt <= tcnt + 16'd1;
                if (tcnt >= LIM - 16'd1) req <= 1'b1;
            end
        end
    end

endmodule
